// File: rtl/m31_pkg.sv
// m31_pkg: shared M31 (p = 2^31 - 1) field definitions.
//   m31_t      - one canonical field element (31 bits, value < p)
//   SHIFTS_16  - internal-diagonal exponents for lanes 1..15 of a width-16 state
//   SHIFTS_24  - internal-diagonal exponents for lanes 1..23 of a width-24 state
//   mod_add / mod_sub / rotl31 - combinational field helpers
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P = 31'h7FFF_FFFF;

  localparam int SHIFTS_16 [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 13, 14, 15, 16};
  localparam int SHIFTS_24 [23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                                    16, 17, 18, 19, 20, 21, 22};

  // End-around carry: 2^31 == 1 (mod p), so the carry bit folds back in.
  function automatic m31_t mod_add(input m31_t a, input m31_t b);
    logic [31:0] t;
    m31_t        r;
    t = {1'b0, a} + {1'b0, b};
    r = t[30:0] + {30'd0, t[31]};
    return (r == P) ? '0 : r;
  endfunction

  // p - 0 would be p itself, which is non-canonical, so negate 0 to 0.
  function automatic m31_t mod_sub(input m31_t a, input m31_t b);
    return mod_add(a, (b == '0) ? '0 : (P - b));
  endfunction

  // 2^k * x mod p is a 31-bit rotate because 2^31 == 1 (mod p).
  function automatic m31_t rotl31(input m31_t x, input int unsigned k);
    m31_t r;
    r = (x << k) | (x >> (31 - k));
    return (r == P) ? '0 : r;
  endfunction

endpackage

// File: rtl/m31_p2_internal_linear.sv
// m31_p2_internal_linear: Poseidon2 internal-round linear layer over M31.
//   out_i = S + D_i * x_i (mod p), S = sum of all lanes, D_0 = -2, D_i = 2^SHIFTS[i-1].
//   Three-stage valid/ready pipeline (S1 register + fold, S2 sum tree, S3 diagonal),
//   one vector per cycle, latency 3. All multiplies are 31-bit rotates.
// Parameters:
//   WIDTH  - state width, 16 or 24 (anything else stops elaboration)
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - input handshake; in_data lane i at [31*i+30 : 31*i]
//   out_valid/out_ready   - output handshake; out_data same packing, always < p
//   out_noncanon          - only when M31_NONCANON_FLAG_EN is defined: set when any
//                           input lane of this vector was 0x7FFFFFFF
module m31_p2_internal_linear
  import m31_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*31-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH*31-1:0]  out_data
`ifdef M31_NONCANON_FLAG_EN
  ,
  output logic                 out_noncanon
`endif
);

  if (WIDTH != 16 && WIDTH != 24) begin : g_bad_width
    $error("m31_p2_internal_linear: WIDTH must be 16 or 24");
  end

  logic ld1, ld2, ld3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  m31_t x1_q [WIDTH];
  m31_t x1_d [WIDTH];
  m31_t x2_q [WIDTH];
  m31_t x2_d [WIDTH];
  m31_t y3_q [WIDTH];
  m31_t y3_d [WIDTH];
  m31_t s2_q, s2_d;
  m31_t sum1;
  m31_t rot2 [WIDTH];

  // A stage loads when it is empty or its contents move on this cycle.
  always_comb begin
    ld3 = !v3_q || out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
  end

  assign in_ready  = ld1;
  assign out_valid = v3_q;

  // Pairwise reduction tree: depth ceil(log2(WIDTH)), result lands in tree[0].
  always_comb begin
    m31_t tree [WIDTH];
    tree = x1_q;
    for (int step = 1; step < WIDTH; step = step * 2) begin
      for (int i = 0; i + step < WIDTH; i = i + 2 * step) begin
        tree[i] = mod_add(tree[i], tree[i + step]);
      end
    end
    sum1 = tree[0];
  end

  // Lane 0 needs 2*x_0 (subtracted later); lanes >= 1 need 2^SHIFTS[i-1] * x_i.
  assign rot2[0] = rotl31(x2_q[0], 1);
  for (genvar i = 1; i < WIDTH; i++) begin : g_rot
    // The modulo keeps the index of the table that is not selected in range.
    localparam int unsigned K = (WIDTH == 16) ? SHIFTS_16[(i - 1) % 15]
                                              : SHIFTS_24[(i - 1) % 23];
    assign rot2[i] = rotl31(x2_q[i], K);
  end

  always_comb begin
    // NOTE: every variable written here gets a value on every path, otherwise a latch is inferred.
    m31_t lane;
    lane = '0;
    v1_d = ld1 ? in_valid : v1_q;
    v2_d = ld2 ? v1_q : v2_q;
    v3_d = ld3 ? v2_q : v3_q;
    s2_d = ld2 ? sum1 : s2_q;
    for (int i = 0; i < WIDTH; i++) begin
      lane    = in_data[31*i +: 31];
      x1_d[i] = ld1 ? ((lane == P) ? '0 : lane) : x1_q[i];
      x2_d[i] = ld2 ? x1_q[i] : x2_q[i];
      if (ld3) begin
        y3_d[i] = (i == 0) ? mod_sub(s2_q, rot2[0]) : mod_add(s2_q, rot2[i]);
      end else begin
        y3_d[i] = y3_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      // NOTE: the data registers are reset as well so out_data reads 0 straight out of reset.
      s2_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y3_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s2_q <= s2_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      y3_q <= y3_d;
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_data[31*i +: 31] = y3_q[i];
    end
  end

`ifdef M31_NONCANON_FLAG_EN
  logic nc1_q, nc1_d, nc2_q, nc2_d, nc3_q, nc3_d;

  // The flag rides alongside the vector through the same stage enables.
  always_comb begin
    nc1_d = nc1_q;
    if (ld1) begin
      nc1_d = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (in_data[31*i +: 31] == P) nc1_d = 1'b1;
      end
    end
    nc2_d = ld2 ? nc1_q : nc2_q;
    nc3_d = ld3 ? nc2_q : nc3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nc1_q <= 1'b0;
      nc2_q <= 1'b0;
      nc3_q <= 1'b0;
    end else begin
      nc1_q <= nc1_d;
      nc2_q <= nc2_d;
      nc3_q <= nc3_d;
    end
  end

  assign out_noncanon = nc3_q;
`endif

endmodule

// File: tb/tb_m31_p2_internal_linear.sv
// Bench for m31_p2_internal_linear: one WIDTH=16 and one WIDTH=24 instance,
// directed vectors with hand-computed results, a backpressure sequence,
// a randomised out_ready scoreboard and a reset-while-busy scenario.
module tb_m31_p2_internal_linear;

  localparam int W16 = 16;
  localparam int W24 = 24;
  localparam logic [30:0] P = 31'h7FFF_FFFF;
  localparam longint unsigned P64 = 64'h7FFF_FFFF;

  typedef logic [W16*31-1:0] vec16_t;
  typedef logic [W24*31-1:0] vec24_t;

  logic   clk;
  logic   rst_n;
  logic   a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  vec16_t a_in_data, a_out_data;
  logic   b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  vec24_t b_in_data, b_out_data;
`ifdef M31_NONCANON_FLAG_EN
  logic   a_noncanon, b_noncanon;
`endif

  int errors = 0;
  int checks = 0;

  int sh16 [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 13, 14, 15, 16};
  int sh24 [23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                    16, 17, 18, 19, 20, 21, 22};

  m31_p2_internal_linear #(.WIDTH(W16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data)
`ifdef M31_NONCANON_FLAG_EN
    ,
    .out_noncanon (a_noncanon)
`endif
  );

  m31_p2_internal_linear #(.WIDTH(W24)) dut24 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data)
`ifdef M31_NONCANON_FLAG_EN
    ,
    .out_noncanon (b_noncanon)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain 64-bit modular arithmetic with explicit multiplications.
  function automatic vec24_t model(input vec24_t v, input int w);
    longint unsigned s, x, d, r;
    vec24_t o;
    o = '0;
    s = 0;
    for (int i = 0; i < w; i++) begin
      x = {33'd0, v[31*i +: 31]};
      if (x == P64) x = 0;
      s = (s + x) % P64;
    end
    for (int i = 0; i < w; i++) begin
      x = {33'd0, v[31*i +: 31]};
      if (x == P64) x = 0;
      if (i == 0)       d = P64 - 2;
      else if (w == 16) d = 64'd1 << sh16[i-1];
      else              d = 64'd1 << sh24[i-1];
      r = (s + (d * x) % P64) % P64;
      o[31*i +: 31] = r[30:0];
    end
    return o;
  endfunction

  function automatic vec24_t pattern(input int k);
    vec24_t v;
    logic [31:0] t;
    v = '0;
    for (int i = 0; i < W24; i++) begin
      t = (32'(k + 1) * 32'h9E37_79B1) ^ (32'(i) * 32'h85EB_CA6B);
      v[31*i +: 31] = (t[30:0] == P) ? 31'd0 : t[30:0];
    end
    return v;
  endfunction

  function automatic vec24_t rand_vec();
    vec24_t v;
    logic [31:0] t;
    v = '0;
    for (int i = 0; i < W24; i++) begin
      t = $urandom();
      case ($urandom_range(0, 7))
        0:       v[31*i +: 31] = 31'd0;
        1:       v[31*i +: 31] = P - 31'd1;
        default: v[31*i +: 31] = (t[30:0] == P) ? 31'd0 : t[30:0];
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid16: got %b expected 0", a_out_valid);
    end
    checks++;
    if (a_out_data !== '0) begin
      errors++; $display("FAIL reset_out_data16: got %h expected 0", a_out_data);
    end
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid24: got %b expected 0", b_out_valid);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready16: got %b expected 1", a_in_ready);
    end
`ifdef M31_NONCANON_FLAG_EN
    checks++;
    if (a_noncanon !== 1'b0) begin
      errors++; $display("FAIL reset_noncanon16: got %b expected 0", a_noncanon);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_w16_directed();
    vec16_t v [4];
    vec16_t e [4];
    v[0] = '0;
    e[0] = '0;
    v[1] = '0;
    v[1][30:0] = 31'd1;
    for (int i = 0; i < W16; i++) e[1][31*i +: 31] = (i == 0) ? 31'h7FFF_FFFE : 31'd1;
    v[2] = '0;
    v[2][31*15 +: 31] = 31'h4000_0000;
    for (int i = 0; i < W16; i++) e[2][31*i +: 31] = (i == 15) ? 31'h4000_8000 : 31'h4000_0000;
    // All lanes -1: S = -16, out_0 = -16 + 2 = -14, out_i = -(16 + 2^k).
    for (int i = 0; i < W16; i++) begin
      v[3][31*i +: 31] = P - 31'd1;
      e[3][31*i +: 31] = (i == 0) ? 31'h7FFF_FFF1 : (P - 31'd16 - (31'd1 << sh16[i-1]));
    end
    for (int k = 0; k < 4; k++) begin
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = v[k];
      @(posedge clk); #1;
      a_in_valid  = 1'b0;
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++; $display("FAIL w16_lat1_vec%0d: got out_valid %b expected 0", k, a_out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++; $display("FAIL w16_lat2_vec%0d: got out_valid %b expected 0", k, a_out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1) begin
        errors++; $display("FAIL w16_lat3_vec%0d: got out_valid %b expected 1", k, a_out_valid);
      end
      checks++;
      if (a_out_data !== e[k]) begin
        errors++; $display("FAIL w16_data_vec%0d: got %h expected %h", k, a_out_data, e[k]);
      end
`ifdef M31_NONCANON_FLAG_EN
      checks++;
      if (a_noncanon !== 1'b0) begin
        errors++; $display("FAIL w16_noncanon_vec%0d: got %b expected 0", k, a_noncanon);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_w24_directed();
    vec24_t v [2];
    vec24_t e [2];
    v[0] = '0;
    v[0][31*23 +: 31] = 31'd1;
    for (int i = 0; i < W24; i++) e[0][31*i +: 31] = (i == 23) ? 31'h0040_0001 : 31'd1;
    v[1] = '0;
    v[1][31*1 +: 31] = 31'd3;
    for (int i = 0; i < W24; i++) e[1][31*i +: 31] = (i == 1) ? 31'd6 : 31'd3;
    for (int k = 0; k < 2; k++) begin
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = v[k];
      @(posedge clk); #1;
      b_in_valid  = 1'b0;
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b0) begin
        errors++; $display("FAIL w24_lat1_vec%0d: got out_valid %b expected 0", k, b_out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b1) begin
        errors++; $display("FAIL w24_lat3_vec%0d: got out_valid %b expected 1", k, b_out_valid);
      end
      checks++;
      if (b_out_data !== e[k]) begin
        errors++; $display("FAIL w24_data_vec%0d: got %h expected %h", k, b_out_data, e[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    vec16_t vec [5];
    vec16_t q [$];
    vec16_t exp_v;
    vec24_t m;
    int acc = 0;
    int got = 0;
    for (int k = 0; k < 5; k++) begin
      m = pattern(k);
      vec[k] = m[W16*31-1:0];
    end
    // Stalled output: only the three stages fill.
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a_in_valid = 1'b1;
      a_in_data  = vec[acc];
      @(negedge clk);
      if (a_in_ready) begin
        m = model({{(W24-W16)*31{1'b0}}, vec[acc]}, W16);
        q.push_back(m[W16*31-1:0]);
        acc++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (acc !== 3) begin
      errors++; $display("FAIL bp_accepted: got %0d expected 3", acc);
    end
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_full: got %b expected 0", a_in_ready);
    end
    checks++;
    if (a_out_valid !== 1'b1 || q.size() == 0 || a_out_data !== q[0]) begin
      errors++; $display("FAIL bp_held_head: got valid %b data %h", a_out_valid, a_out_data);
    end
    @(posedge clk); #1;
    // Release: outputs drain in order, remaining vectors enter with no bubble.
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      a_out_ready = 1'b1;
      a_in_valid  = (acc < 5);
      a_in_data   = (acc < 5) ? vec[acc] : '0;
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          errors++; $display("FAIL bp_no_bubble: got in_ready %b expected 1", a_in_ready);
        end
      end
      if (a_out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra_output: got %h expected none", a_out_data);
        end else begin
          exp_v = q.pop_front();
          if (a_out_data !== exp_v) begin
            errors++; $display("FAIL bp_order_%0d: got %h expected %h", got, a_out_data, exp_v);
          end
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        m = model({{(W24-W16)*31{1'b0}}, vec[acc]}, W16);
        q.push_back(m[W16*31-1:0]);
        acc++;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    checks++;
    if (got !== 5 || acc !== 5) begin
      errors++; $display("FAIL bp_drain: got %0d outputs %0d accepted expected 5 and 5", got, acc);
    end
  endtask

  task automatic test_random_ready();
    vec24_t q [$];
    vec24_t cur, exp_v, prev;
    int n = 20;
    int sent = 0;
    int got = 0;
    logic hold = 1'b0;
    prev = '0;
    cur  = rand_vec();
    for (int cyc = 0; cyc < 600 && got < n; cyc++) begin
      b_in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      b_in_data   = cur;
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (hold) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== prev) begin
          errors++; $display("FAIL rnd_hold: got valid %b data %h expected %h", b_out_valid, b_out_data, prev);
        end
      end
      hold = b_out_valid && !b_out_ready;
      prev = b_out_data;
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_output: got %h expected none", b_out_data);
        end else begin
          exp_v = q.pop_front();
          if (b_out_data !== exp_v) begin
            errors++; $display("FAIL rnd_data_%0d: got %h expected %h", got, b_out_data, exp_v);
          end
        end
        got++;
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back(model(cur, W24));
        sent++;
        cur = rand_vec();
      end
      @(posedge clk); #1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    checks++;
    if (got !== n) begin
      errors++; $display("FAIL rnd_count: got %0d outputs expected %0d", got, n);
    end
  endtask

  task automatic test_reset_midflight();
    vec24_t m;
    vec16_t v;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    m = pattern(10);
    a_in_data = m[W16*31-1:0];
    @(posedge clk); #1;
    m = pattern(11);
    a_in_data = m[W16*31-1:0];
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_valid: got %b expected 1", a_out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async_valid: got %b expected 0", a_out_valid);
    end
    checks++;
    if (a_out_data !== '0) begin
      errors++; $display("FAIL rst_async_data: got %h expected 0", a_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = '0;
    v[31*1 +: 31] = P;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = v;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after_in_ready: got %b expected 1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_flushed: got out_valid %b expected 0", a_out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1) begin
      errors++; $display("FAIL fold_valid: got %b expected 1", a_out_valid);
    end
    checks++;
    if (a_out_data !== '0) begin
      errors++; $display("FAIL fold_data: got %h expected 0", a_out_data);
    end
`ifdef M31_NONCANON_FLAG_EN
    checks++;
    if (a_noncanon !== 1'b1) begin
      errors++; $display("FAIL fold_noncanon: got %b expected 1", a_noncanon);
    end
`endif
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL fold_single: got out_valid %b expected 0", a_out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b1;
    test_reset();
    test_w16_directed();
    test_w24_directed();
    test_backpressure();
    test_random_ready();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m31_p2_internal_linear.md
Name: m31_p2_internal_linear

Overview:
- Poseidon2 internal-round linear layer over M31 (p = 2^31-1), computing out_i = S + D_i*x_i, where S = sum of all lanes mod p.
- Diagonal: D_0 = -2; D_i = 2^SHIFTS[i-1] for i >= 1, using SHIFTS_16 / SHIFTS_24 from m31_pkg.
- Sits directly downstream of the partial-round S-box (lane 0 only) and feeds the next partial round.
- 3-stage valid/ready pipeline; every multiply is a 31-bit rotate, so the block contains no multipliers.

Parameters:
- WIDTH, 16: state width. Only 16 or 24 are legal; any other value is an elaboration error. Selects SHIFTS_16 or SHIFTS_24.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts the vector this cycle
- in_data  in  WIDTH*31  lane i at bits [31*i+30 : 31*i], type m31_t
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH*31  same lane packing; always canonical (< p)

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0; out_data = 0.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - out_valid/out_data hold stable until transferred; in_valid is not required to be held.
- Pipeline S1 -> S2 -> S3; S3 drives the outputs. Stage k advances when it is empty or stage k+1 advances. in_ready = !v1 | adv1, combinational from out_ready.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 vector/cycle.
- S1: register lanes; fold any 0x7FFFFFFF input to 0.
- S2: S = modular sum tree of all lanes (log2 depth, combinational); register S and the lanes.
- S3:
  - lane 0: out_0 = S - 2*x_0 mod p, with 2*x_0 = rotl1(x_0).
  - lane i >= 1: out_i = S + rotl(x_i, SHIFTS[i-1]) mod p.
- mod add: t = a + b (32 bits); r = t[30:0] + t[31]; if r == p then r = 0.
- mod sub: a + (p - b) with the same reduction; p - 0 is treated as 0.
- Rotate by k < 31 is exact: 2^k*x mod p = rotl31(x, k). A result of 0x7FFFFFFF is mapped to 0.
- Full pipeline with out_ready = 0: in_ready = 0 once S1..S3 all hold data; no vector is dropped or duplicated; order is preserved.
- Simultaneous output and input transfer on a full pipeline: accepted with no bubble.
- Reset mid-operation: all in-flight vectors are discarded; out_valid = 0 asynchronously.

Optional Feature:
- Macro: M31_NONCANON_FLAG_EN.
- Defined:
  - Extra output port out_noncanon (1 bit) travels with out_data.
  - Set when any lane of that vector arrived as 0x7FFFFFFF; reset value 0.
  - The arithmetic still treats such a lane as 0.
- Undefined: port absent; 0x7FFFFFFF is silently folded to 0.

Test Plan:
- WIDTH=16, all lanes 0 -> after 3 cycles out_valid = 1, all out lanes 0.
- WIDTH=16, lane0 = 1, rest 0 -> out_0 = 0x7FFFFFFE; out_1..out_15 = 1.
- WIDTH=16, lane15 = 0x40000000, rest 0 -> S = 2^30; out_15 = 0x40008000 (2^46 mod p = 2^15); out_0..out_14 = 0x40000000.
- WIDTH=24, lane23 = 1 -> out_23 = 0x00400001 (1 + 2^22); all other lanes 1; lane1 = 3 -> out_1 = 6 with sum 3.
- Backpressure:
  - Stimulus: out_ready = 0, 5 distinct vectors offered back to back.
  - Response: exactly 3 accepted, then in_ready = 0.
  - Release out_ready: outputs appear in order with no loss, then the remaining 2 are accepted.
  - Random out_ready: scoreboard matches a golden model.
- Reset asserted with 2 vectors in flight -> out_valid = 0 immediately.
  - After release: the next vector is lane1 = 0x7FFFFFFF.
  - Response: treated as 0, all outputs 0; out_noncanon = 1 when M31_NONCANON_FLAG_EN is defined.
